// File: rtl/stack_mc_controller_pkg.sv
// Shared encodings for the multicycle stack-processor controller: FSM states,
// opcodes, datapath select codes, trap codes and opcode decode helpers.
package stack_mc_controller_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_IF   = 4'd1,
      S_ID   = 4'd2,
      S_POPA = 4'd3,
      S_POPB = 4'd4,
      S_LDA  = 4'd5,
      S_WB   = 4'd6,
      S_PSHA = 4'd7,
      S_PSHB = 4'd8,
      S_MRD  = 4'd9,
      S_MWR  = 4'd10,
      S_JMP  = 4'd11,
      S_JZ   = 4'd12,
      S_HALT = 4'd13,
      S_TRAP = 4'd14
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_NOT  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_POP  = 4'd5;
   localparam logic [3:0] OP_JMP  = 4'd6;
   localparam logic [3:0] OP_JZ   = 4'd7;
   localparam logic [3:0] OP_DUP  = 4'd8;
   localparam logic [3:0] OP_SWAP = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   localparam logic [1:0] PS_B   = 2'b00;
   localparam logic [1:0] PS_MEM = 2'b01;
   localparam logic [1:0] PS_ALU = 2'b10;
   localparam logic [1:0] PS_A   = 2'b11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_ZERO = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_UNDER   = 2'b01;
   localparam logic [1:0] TRAP_OVER    = 2'b10;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b11;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_PUSH, OP_POP,
         OP_JMP, OP_JZ, OP_DUP, OP_SWAP, OP_HALT: ok = 1'b1;
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Entries the stack must hold before the instruction may start.
   function automatic logic [1:0] op_min_depth(input logic [3:0] op);
      logic [1:0] n;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_SWAP: n = 2'd2;
         OP_NOT, OP_POP, OP_JZ, OP_DUP:   n = 2'd1;
         default:                         n = 2'd0;
      endcase
      return n;
   endfunction

   function automatic logic op_needs_slot(input logic [3:0] op);
      logic s;
      case (op)
         OP_DUP, OP_PUSH: s = 1'b1;
         default:         s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] op_alu(input logic [3:0] op);
      logic [1:0] a;
      case (op)
         OP_SUB:  a = ALU_SUB;
         OP_AND:  a = ALU_AND;
         OP_NOT:  a = ALU_NOT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // First execute state after a clean decode.
   function automatic state_t op_entry(input logic [3:0] op);
      state_t s;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_JZ, OP_SWAP: s = S_POPA;
         OP_DUP:  s = S_LDA;
         OP_PUSH: s = S_MRD;
         OP_POP:  s = S_MWR;
         OP_JMP:  s = S_JMP;
         OP_HALT: s = S_HALT;
         default: s = S_TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/stack_mc_controller_depth_counter.sv
// Tracks stack occupancy from the controller's push/pop strobes and reports
// whether one or two pops, or one push, are currently safe.
module stack_mc_controller_depth_counter #(
   parameter int CNT_W = 5,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   output logic [CNT_W-1:0] depth,
   output logic             can_pop1,
   output logic             can_pop2,
   output logic             can_push1
);

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEPTH);

   // Occupancy register; simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else if (push && !pop) begin
         depth <= depth + ONE;
      end else if (pop && !push) begin
         depth <= depth - ONE;
      end else begin
         depth <= depth;
      end
   end

   assign can_pop1  = (depth >= ONE);
   assign can_pop2  = (depth >= TWO);
   assign can_push1 = (depth < LIMIT);

endmodule

// File: rtl/stack_mc_controller.sv
// Multicycle Moore controller for the stack datapath with memory wait
// handshake, stack-depth tracking and sticky underflow/overflow/illegal traps.
module stack_mc_controller
   import stack_mc_controller_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int CNT_W    = 5,
   parameter int MEM_WAIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             iord,
   output logic             pc_write,
   output logic             pc_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             push,
   output logic             pop,
   output logic             tos,
   output logic             a_write,
   output logic             b_write,
   output logic             aorb,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       push_src,
   output logic [CNT_W-1:0] depth,
   output logic             trap,
   output logic [1:0]       trap_code,
   output logic             halted
);

   localparam logic WAIT_EN = (MEM_WAIT != 0);

   state_t     state_r;
   logic [1:0] trap_code_r;
   logic       rdy_s;
   logic       can_pop1_s;
   logic       can_pop2_s;
   logic       can_push1_s;
   logic       underflow_s;
   logic       overflow_s;

   assign rdy_s = mem_ready | ~WAIT_EN;

   stack_mc_controller_depth_counter #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) u_depth (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .depth     (depth),
      .can_pop1  (can_pop1_s),
      .can_pop2  (can_pop2_s),
      .can_push1 (can_push1_s)
   );

   // Stack precondition checks for the opcode currently in IR.
   always_comb begin
      underflow_s = 1'b0;
      overflow_s  = 1'b0;
      case (op_min_depth(opcode))
         2'd2:    underflow_s = ~can_pop2_s;
         2'd1:    underflow_s = ~can_pop1_s;
         default: underflow_s = 1'b0;
      endcase
      if (op_needs_slot(opcode)) begin
         overflow_s = ~can_push1_s;
      end else begin
         overflow_s = 1'b0;
      end
   end

   // State sequencing; trap_code is captured only when decode rejects an opcode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         trap_code_r <= TRAP_NONE;
      end else begin
         case (state_r)
            S_IDLE: state_r <= S_IF;
            S_IF: begin
               if (rdy_s) state_r <= S_ID;
               else       state_r <= S_IF;
            end
            S_ID: begin
               if (!op_legal(opcode)) begin
                  state_r     <= S_TRAP;
                  trap_code_r <= TRAP_ILLEGAL;
               end else if (underflow_s) begin
                  state_r     <= S_TRAP;
                  trap_code_r <= TRAP_UNDER;
               end else if (overflow_s) begin
                  state_r     <= S_TRAP;
                  trap_code_r <= TRAP_OVER;
               end else begin
                  state_r <= op_entry(opcode);
               end
            end
            S_POPA: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_SWAP: state_r <= S_POPB;
                  OP_NOT:  state_r <= S_WB;
                  OP_JZ:   state_r <= S_JZ;
                  default: state_r <= S_IF;
               endcase
            end
            S_POPB: begin
               if (opcode == OP_SWAP) state_r <= S_PSHA;
               else                   state_r <= S_WB;
            end
            S_LDA: state_r <= S_PSHA;
            S_PSHA: begin
               if (opcode == OP_SWAP) state_r <= S_PSHB;
               else                   state_r <= S_IF;
            end
            S_MRD, S_MWR: begin
               if (rdy_s) state_r <= S_IF;
               else       state_r <= state_r;
            end
            S_WB, S_PSHB, S_JMP, S_JZ: state_r <= S_IF;
            S_HALT: state_r <= S_HALT;
            S_TRAP: state_r <= S_TRAP;
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // Moore output decode from the state register (mem_ready/zero gate a few strobes).
   always_comb begin
      iord      = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      tos       = 1'b0;
      a_write   = 1'b0;
      b_write   = 1'b0;
      aorb      = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_B;
      alu_op    = ALU_ADD;
      push_src  = PS_B;
      trap      = 1'b0;
      halted    = 1'b0;
      trap_code = trap_code_r;
      case (state_r)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_ONE;
            pc_write  = rdy_s;
            ir_write  = rdy_s;
         end
         S_POPA: begin
            pop     = 1'b1;
            a_write = 1'b1;
         end
         S_POPB: begin
            pop     = 1'b1;
            b_write = 1'b1;
            aorb    = 1'b1;
         end
         S_LDA: begin
            tos     = 1'b1;
            a_write = 1'b1;
         end
         S_WB: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = op_alu(opcode);
            push      = 1'b1;
            push_src  = PS_ALU;
         end
         S_PSHA: begin
            push     = 1'b1;
            push_src = PS_A;
         end
         S_PSHB: begin
            push     = 1'b1;
            push_src = PS_B;
         end
         S_MRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            push_src = PS_MEM;
            push     = rdy_s;
         end
         S_MWR: begin
            iord      = 1'b1;
            tos       = 1'b1;
            mem_write = 1'b1;
            pop       = rdy_s;
         end
         S_JMP: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
         end
         S_JZ: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_ZERO;
            alu_op    = ALU_ADD;
            pc_src    = zero;
            pc_write  = zero;
         end
         S_HALT: halted = 1'b1;
         S_TRAP: trap = 1'b1;
         default: trap_code = trap_code_r;
      endcase
   end

endmodule

// File: tb/tb_stack_mc_controller.sv
// Scoreboard bench for stack_mc_controller: per-cycle expected control words
// and depth are queued with the stimulus and compared when the cycle completes.
module tb_stack_mc_controller;

   localparam logic [3:0] O_ADD = 4'd0, O_SUB = 4'd1, O_AND = 4'd2, O_NOT = 4'd3;
   localparam logic [3:0] O_PUSH = 4'd4, O_POP = 4'd5, O_JMP = 4'd6, O_JZ = 4'd7;
   localparam logic [3:0] O_DUP = 4'd8, O_SWAP = 4'd9, O_HALT = 4'd15;

   localparam logic [22:0] C_IORD  = 23'd1 << 22;
   localparam logic [22:0] C_PCW   = 23'd1 << 21;
   localparam logic [22:0] C_PCSRC = 23'd1 << 20;
   localparam logic [22:0] C_MRD   = 23'd1 << 19;
   localparam logic [22:0] C_MWR   = 23'd1 << 18;
   localparam logic [22:0] C_IRW   = 23'd1 << 17;
   localparam logic [22:0] C_PUSH  = 23'd1 << 16;
   localparam logic [22:0] C_POP   = 23'd1 << 15;
   localparam logic [22:0] C_TOS   = 23'd1 << 14;
   localparam logic [22:0] C_AW    = 23'd1 << 13;
   localparam logic [22:0] C_BW    = 23'd1 << 12;
   localparam logic [22:0] C_AORB  = 23'd1 << 11;
   localparam logic [22:0] C_ASA   = 23'd1 << 10;
   localparam logic [22:0] SB_ONE  = 23'd1 << 8;
   localparam logic [22:0] SB_ZERO = 23'd2 << 8;
   localparam logic [22:0] AO_SUB  = 23'd1 << 6;
   localparam logic [22:0] AO_AND  = 23'd2 << 6;
   localparam logic [22:0] AO_NOT  = 23'd3 << 6;
   localparam logic [22:0] PS_MEM  = 23'd1 << 4;
   localparam logic [22:0] PS_ALU  = 23'd2 << 4;
   localparam logic [22:0] PS_A    = 23'd3 << 4;
   localparam logic [22:0] C_TRAP  = 23'd1 << 3;
   localparam logic [22:0] TC_UF   = 23'd1 << 1;
   localparam logic [22:0] TC_OF   = 23'd2 << 1;
   localparam logic [22:0] TC_ILL  = 23'd3 << 1;
   localparam logic [22:0] C_HALT  = 23'd1;
   localparam logic [22:0] IF_GO   = C_MRD | SB_ONE | C_PCW | C_IRW;
   localparam logic [22:0] IF_WAIT = C_MRD | SB_ONE;
   localparam logic [22:0] MRD_W   = C_IORD | C_MRD | PS_MEM;
   localparam logic [22:0] MWR_W   = C_IORD | C_TOS | C_MWR;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       iord, pc_write, pc_src, mem_read, mem_write, ir_write;
   logic       push, pop, tos, a_write, b_write, aorb, alu_src_a;
   logic [1:0] alu_src_b, alu_op, push_src, trap_code;
   logic [4:0] depth;
   logic       trap, halted;
   logic [22:0] ctrl_s;

   always #5 clk = ~clk;

   stack_mc_controller #(.DEPTH(16), .CNT_W(5), .MEM_WAIT(1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .push(push), .pop(pop), .tos(tos),
      .a_write(a_write), .b_write(b_write), .aorb(aorb), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .push_src(push_src), .depth(depth),
      .trap(trap), .trap_code(trap_code), .halted(halted)
   );

   assign ctrl_s = {iord, pc_write, pc_src, mem_read, mem_write, ir_write, push, pop, tos,
                    a_write, b_write, aorb, alu_src_a, alu_src_b, alu_op, push_src,
                    trap, trap_code, halted};

   typedef struct {
      string       tag;
      logic [3:0]  opc;
      logic        z;
      logic        rdy;
      logic [22:0] ctrl;
      logic [4:0]  dep;
   } ent_t;

   ent_t stim_q[$];
   ent_t exp_q[$];
   int   d_exp = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue one cycle: inputs, expected outputs, expected depth, then depth change.
   task automatic ex(input string tag, input logic [3:0] opc, input logic z, input logic rdy,
                     input logic [22:0] c, input int dd);
      ent_t e;
      e.tag = tag; e.opc = opc; e.z = z; e.rdy = rdy; e.ctrl = c; e.dep = d_exp[4:0];
      stim_q.push_back(e);
      d_exp += dd;
   endtask

   task automatic instr(input logic [3:0] opc, input logic z, input int waits);
      logic [22:0] aop;
      aop = (opc == O_SUB) ? AO_SUB : (opc == O_AND) ? AO_AND : (opc == O_NOT) ? AO_NOT : 23'd0;
      ex("IF", opc, z, 1'b1, IF_GO, 0);
      ex("ID", opc, z, 1'b1, 23'd0, 0);
      case (opc)
         O_ADD, O_SUB, O_AND: begin
            ex("POPA", opc, z, 1'b1, C_POP | C_AW, -1);
            ex("POPB", opc, z, 1'b1, C_POP | C_BW | C_AORB, -1);
            ex("WB", opc, z, 1'b1, C_ASA | C_PUSH | PS_ALU | aop, 1);
         end
         O_NOT: begin
            ex("POPA", opc, z, 1'b1, C_POP | C_AW, -1);
            ex("WB", opc, z, 1'b1, C_ASA | C_PUSH | PS_ALU | aop, 1);
         end
         O_SWAP: begin
            ex("POPA", opc, z, 1'b1, C_POP | C_AW, -1);
            ex("POPB", opc, z, 1'b1, C_POP | C_BW | C_AORB, -1);
            ex("PSHA", opc, z, 1'b1, C_PUSH | PS_A, 1);
            ex("PSHB", opc, z, 1'b1, C_PUSH, 1);
         end
         O_DUP: begin
            ex("LDA", opc, z, 1'b1, C_TOS | C_AW, 0);
            ex("PSHA", opc, z, 1'b1, C_PUSH | PS_A, 1);
         end
         O_PUSH: begin
            for (int i = 0; i < waits; i++) ex("MRD_WAIT", opc, z, 1'b0, MRD_W, 0);
            ex("MRD", opc, z, 1'b1, MRD_W | C_PUSH, 1);
         end
         O_POP: begin
            for (int i = 0; i < waits; i++) ex("MWR_WAIT", opc, z, 1'b0, MWR_W, 0);
            ex("MWR", opc, z, 1'b1, MWR_W | C_POP, -1);
         end
         O_JMP: ex("JMP", opc, z, 1'b1, C_PCW | C_PCSRC, 0);
         O_JZ: begin
            ex("POPA", opc, z, 1'b1, C_POP | C_AW, -1);
            ex("JZ", opc, z, 1'b1, C_ASA | SB_ZERO | (z ? (C_PCW | C_PCSRC) : 23'd0), 0);
         end
         O_HALT: for (int i = 0; i < 21; i++) ex("HALT", opc, z, i[0], C_HALT, 0);
         default: ex("UNEXPECTED", opc, z, 1'b1, 23'd0, 0);
      endcase
   endtask

   // Rejected opcode: TRAP must hold regardless of later inputs.
   task automatic trap_op(input logic [3:0] opc, input logic [22:0] code);
      ex("IF", opc, 1'b0, 1'b1, IF_GO, 0);
      ex("ID", opc, 1'b0, 1'b1, 23'd0, 0);
      for (int i = 0; i < 5; i++) ex("TRAP", 4'(i + 4), i[0], i[1], C_TRAP | code, 0);
   endtask

   task automatic run_q();
      ent_t e;
      ent_t x;
      while (stim_q.size() != 0) begin
         e = stim_q.pop_front();
         opcode = e.opc; zero = e.z; mem_ready = e.rdy;
         exp_q.push_back(e);
         @(negedge clk);
         x = exp_q.pop_front();
         chk({x.tag, "_ctrl"}, 32'(ctrl_s), 32'(x.ctrl));
         chk({x.tag, "_depth"}, 32'(depth), 32'(x.dep));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", 32'(ctrl_s), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d_exp = 0;
      ex("IDLE", 4'd0, 1'b0, 1'b0, 23'd0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // PUSH with memory stalls, preceded by a stalled fetch
      do_reset();
      ex("IF_WAIT", O_PUSH, 1'b0, 1'b0, IF_WAIT, 0);
      ex("IF_WAIT", O_PUSH, 1'b0, 1'b0, IF_WAIT, 0);
      instr(O_PUSH, 1'b0, 3);
      run_q();

      // Arithmetic, SWAP, DUP, jumps, then underflow trap at depth 0
      do_reset();
      instr(O_PUSH, 1'b0, 0);
      instr(O_PUSH, 1'b0, 1);
      instr(O_ADD, 1'b0, 0);
      instr(O_PUSH, 1'b0, 0);
      instr(O_SWAP, 1'b0, 0);
      instr(O_SUB, 1'b0, 0);
      instr(O_PUSH, 1'b0, 0);
      instr(O_AND, 1'b0, 0);
      instr(O_NOT, 1'b0, 0);
      instr(O_DUP, 1'b0, 0);
      instr(O_JZ, 1'b1, 0);
      instr(O_JZ, 1'b0, 0);
      instr(O_JMP, 1'b0, 0);
      trap_op(O_POP, TC_UF);
      run_q();

      // Fill to DEPTH, stalled POP, refill, DUP overflows
      do_reset();
      for (int i = 0; i < 16; i++) instr(O_PUSH, 1'b0, 0);
      instr(O_POP, 1'b0, 2);
      instr(O_PUSH, 1'b0, 0);
      trap_op(O_DUP, TC_OF);
      run_q();

      do_reset();
      trap_op(4'd12, TC_ILL);
      run_q();

      do_reset();
      instr(O_PUSH, 1'b0, 0);
      trap_op(O_SWAP, TC_UF);
      run_q();

      do_reset();
      instr(O_HALT, 1'b0, 0);
      run_q();

      // Asynchronous reset while MRD is stalled
      do_reset();
      instr(O_PUSH, 1'b0, 0);
      ex("IF", O_PUSH, 1'b0, 1'b1, IF_GO, 0);
      ex("ID", O_PUSH, 1'b0, 1'b1, 23'd0, 0);
      ex("MRD_WAIT", O_PUSH, 1'b0, 1'b0, MRD_W, 0);
      ex("MRD_WAIT", O_PUSH, 1'b0, 1'b0, MRD_W, 0);
      run_q();
      mem_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ctrl", 32'(ctrl_s), 32'd0);
      chk("async_rst_depth", 32'(depth), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d_exp = 0;
      ex("IDLE", O_PUSH, 1'b0, 1'b1, 23'd0, 0);
      ex("IF", O_PUSH, 1'b0, 1'b1, IF_GO, 0);
      run_q();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
